// File: rtl/ebpc_symbol_encoder.sv
// ebpc_pkg: shared EBPC geometry constants.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ebpc_pkg;
    localparam int unsigned DATA_W     = 8;  // word width; a block carries DATA_W+1 planes
    localparam int unsigned BLOCK_SIZE = 8;  // words per block; plane width is BLOCK_SIZE-1
    localparam int unsigned LOG_DATA_W = 3;  // log2(DATA_W)
    localparam int unsigned LOGN       = 3;  // $clog2(BLOCK_SIZE-1)
endpackage

// ebpc_symbol_encoder: turns a base word plus DATA_W+1 delta bit-planes into MSB-aligned EBPC symbols.
// Latency: 1 cycle from input handshake to symbol; zero planes yield no symbol, run flush costs 1 bubble.
// Backpressure: rdy_o follows the output register (!vld_o | rdy_i) and drops for one cycle per run flush.
// Ports: clk_i/rst_ni (async active-low) clock and reset; clr_i synchronous soft clear;
//        data_i/vld_i/rdy_o input beats (base word, then planes in data_i[DATA_W-1 -: N]);
//        data_o/len_o/last_o/vld_o/rdy_i symbol stream to the bit packer.
module ebpc_symbol_encoder
    import ebpc_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  vld_i,
    output logic                  rdy_o,
    output logic [DATA_W-1:0]     data_o,
    output logic [LOG_DATA_W:0]   len_o,
    output logic                  last_o,
    output logic                  vld_o,
    input  logic                  rdy_i
);

    localparam int unsigned N     = BLOCK_SIZE - 1;
    localparam int unsigned LEN_W = LOG_DATA_W + 1;
    localparam int unsigned CNT_W = LOG_DATA_W + 1;   // holds 0..DATA_W+1

    // Left shifts that MSB-align each symbol class inside DATA_W bits.
    localparam int unsigned SH2 = DATA_W - 2;
    localparam int unsigned SH5 = DATA_W - 5;
    localparam int unsigned SHK = DATA_W - 5 - LOGN;
    localparam int unsigned SHR = DATA_W - 3 - LOG_DATA_W;
    localparam int unsigned SHB = DATA_W - BLOCK_SIZE;

    typedef enum logic {ST_BASE, ST_PLANES} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    plane_cnt_q, plane_cnt_d;
    logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
    logic [N-1:0]        dbp_prev_q, dbp_prev_d;

    logic [N-1:0]        plane, dbx;
    logic [LOGN:0]       ones;
    logic [LOGN-1:0]     low_idx;
    logic                adj_pair;
    logic [DATA_W-1:0]   psym_dat, rsym_dat;
    logic [LEN_W-1:0]    psym_len, rsym_len;
    logic [CNT_W-1:0]    run_val;
    logic [LOG_DATA_W-1:0] run_field;

    logic                out_free, flush, acc, last_plane;
    logic                load, ld_last;
    logic [DATA_W-1:0]   ld_dat;
    logic [LEN_W-1:0]    ld_len;

    assign plane = data_i[DATA_W-1 -: N];
    assign dbx   = plane ^ dbp_prev_q;

    // Popcount and lowest set bit of dbx; for a pair of adjacent ones the
    // lowest index is the k the decoder expects.
    always_comb begin
        ones    = '0;
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (dbx[i]) begin
                ones    = ones + 1'b1;
                low_idx = LOGN'(i);
            end
        end
    end

    assign adj_pair = (ones == (LOGN+1)'(2)) && ((dbx & (dbx >> 1)) != '0);

    // Plane symbol, first matching class wins.
    always_comb begin
        psym_dat = '0;
        psym_len = LEN_W'(5);
        if (dbx == '1) begin
            psym_dat = '0;
            psym_len = LEN_W'(5);
        end else if (plane == '0) begin
            psym_dat = DATA_W'(5'b00001) << SH5;
            psym_len = LEN_W'(5);
        end else if (adj_pair) begin
            psym_dat = DATA_W'({5'b00010, low_idx}) << SHK;
            psym_len = LEN_W'(5 + LOGN);
        end else if (ones == (LOGN+1)'(1)) begin
            psym_dat = DATA_W'({5'b00011, low_idx}) << SHK;
            psym_len = LEN_W'(5 + LOGN);
        end else begin
            psym_dat = DATA_W'({1'b1, dbx}) << SHB;
            psym_len = LEN_W'(BLOCK_SIZE);
        end
    end

    // Run symbol. On the final plane a zero dbx extends the run by one, so
    // the emitted length already includes the current plane.
    assign run_val   = (dbx == '0) ? run_cnt_q + 1'b1 : run_cnt_q;
    assign run_field = LOG_DATA_W'(run_val - CNT_W'(2));

    always_comb begin
        rsym_dat = DATA_W'({3'b001, run_field}) << SHR;
        rsym_len = LEN_W'(3 + LOG_DATA_W);
        if (run_val == CNT_W'(1)) begin
            rsym_dat = DATA_W'(2'b01) << SH2;
            rsym_len = LEN_W'(2);
        end
    end

    assign out_free   = !vld_o || rdy_i;
    // A pending run must be emitted before the nonzero plane, so the plane is held one cycle.
    assign flush      = (state_q == ST_PLANES) && (run_cnt_q != '0) && (dbx != '0);
    assign rdy_o      = out_free && !flush;
    assign acc        = vld_i && rdy_o;
    assign last_plane = (plane_cnt_q == CNT_W'(DATA_W));

    always_comb begin
        state_d     = state_q;
        plane_cnt_d = plane_cnt_q;
        run_cnt_d   = run_cnt_q;
        dbp_prev_d  = dbp_prev_q;
        load        = 1'b0;
        ld_dat      = '0;
        ld_len      = '0;
        ld_last     = 1'b0;
        case (state_q)
            ST_BASE: begin
                if (acc) begin
                    load        = 1'b1;
                    ld_dat      = data_i;
                    ld_len      = LEN_W'(DATA_W);
                    plane_cnt_d = '0;
                    run_cnt_d   = '0;
                    dbp_prev_d  = '0;
                    state_d     = ST_PLANES;
                end
            end
            ST_PLANES: begin
                if (flush && vld_i && out_free) begin
                    load      = 1'b1;
                    ld_dat    = rsym_dat;
                    ld_len    = rsym_len;
                    run_cnt_d = '0;
                end else if (acc) begin
                    dbp_prev_d  = plane;
                    plane_cnt_d = plane_cnt_q + 1'b1;
                    if (dbx == '0) begin
                        if (last_plane) begin
                            load      = 1'b1;
                            ld_dat    = rsym_dat;
                            ld_len    = rsym_len;
                            ld_last   = 1'b1;
                            run_cnt_d = '0;
                        end else begin
                            run_cnt_d = run_cnt_q + 1'b1;
                        end
                    end else begin
                        load    = 1'b1;
                        ld_dat  = psym_dat;
                        ld_len  = psym_len;
                        ld_last = last_plane;
                    end
                    if (last_plane) begin
                        state_d = ST_BASE;
                    end
                end
            end
            default: state_d = ST_BASE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_BASE;
            plane_cnt_q <= '0;
            run_cnt_q   <= '0;
            dbp_prev_q  <= '0;
            data_o      <= '0;
            len_o       <= '0;
            last_o      <= 1'b0;
            vld_o       <= 1'b0;
        end else if (clr_i) begin
            state_q     <= ST_BASE;
            plane_cnt_q <= '0;
            run_cnt_q   <= '0;
            dbp_prev_q  <= '0;
            data_o      <= '0;
            len_o       <= '0;
            last_o      <= 1'b0;
            vld_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            plane_cnt_q <= plane_cnt_d;
            run_cnt_q   <= run_cnt_d;
            dbp_prev_q  <= dbp_prev_d;
            if (out_free) begin
                vld_o <= load;
                if (load) begin
                    data_o <= ld_dat;
                    len_o  <= ld_len;
                    last_o <= ld_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_ebpc_symbol_encoder.sv
// tb_ebpc_symbol_encoder: randomized and directed bench for ebpc_symbol_encoder with a block-level reference model.
// Latency: n/a.
// Backpressure: rdy_i is either forced or randomized by a dedicated process.
module tb_ebpc_symbol_encoder;
    import ebpc_pkg::*;

    localparam int NP    = BLOCK_SIZE - 1;
    localparam int NBEAT = DATA_W + 2;

    logic                clk_i  = 1'b0;
    logic                rst_ni = 1'b0;
    logic                clr_i  = 1'b0;
    logic [DATA_W-1:0]   data_i = '0;
    logic                vld_i  = 1'b0;
    logic                rdy_o;
    logic [DATA_W-1:0]   data_o;
    logic [LOG_DATA_W:0] len_o;
    logic                last_o;
    logic                vld_o;
    logic                rdy_i  = 1'b1;

    ebpc_symbol_encoder dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .data_i (data_i),
        .vld_i  (vld_i),
        .rdy_o  (rdy_o),
        .data_o (data_o),
        .len_o  (len_o),
        .last_o (last_o),
        .vld_o  (vld_o),
        .rdy_i  (rdy_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int dat;
        int len;
        bit last;
    } sym_t;

    sym_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   rnd_rdy  = 1'b0;
    bit   rdy_force = 1'b1;
    int   blk_base;
    int   blk_pl[DATA_W+1];
    int   waits_arr[NBEAT];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // code is the symbol value right-aligned in len bits.
    function automatic void push_sym(input int code, input int len, input bit last);
        sym_t s;
        s.dat  = (code << (DATA_W - len)) & ((1 << DATA_W) - 1);
        s.len  = len;
        s.last = last;
        exp_q.push_back(s);
    endfunction

    function automatic void push_lit(input int dat, input int len, input bit last);
        sym_t s;
        s.dat  = dat;
        s.len  = len;
        s.last = last;
        exp_q.push_back(s);
    endfunction

    function automatic void run_sym(input int r, input bit last);
        if (r == 1) push_sym(1, 2, last);
        else        push_sym((1 << LOG_DATA_W) + (r - 2), 3 + LOG_DATA_W, last);
    endfunction

    function automatic void plane_sym(input int plane, input int dbx, input bit last);
        int cnt = 0;
        int lo  = -1;
        int hi  = -1;
        for (int i = 0; i < NP; i++) begin
            if (((dbx >> i) & 1) == 1) begin
                cnt++;
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        if (dbx == (1 << NP) - 1)          push_sym(0, 5, last);
        else if (plane == 0)               push_sym(1, 5, last);
        else if (cnt == 2 && hi == lo + 1) push_sym((2 << LOGN) + lo, 5 + LOGN, last);
        else if (cnt == 1)                 push_sym((3 << LOGN) + lo, 5 + LOGN, last);
        else                               push_sym((1 << NP) + dbx, BLOCK_SIZE, last);
    endfunction

    // Expected symbols for the block in blk_base/blk_pl, in decode order.
    function automatic void model_block();
        int prev = 0;
        int run  = 0;
        int dbx;
        bit last;
        push_sym(blk_base, DATA_W, 1'b0);
        for (int p = 0; p <= DATA_W; p++) begin
            dbx  = blk_pl[p] ^ prev;
            prev = blk_pl[p];
            last = (p == DATA_W);
            if (dbx == 0) begin
                run++;
                if (last) run_sym(run, 1'b1);
            end else begin
                if (run > 0) run_sym(run, 1'b0);
                run = 0;
                plane_sym(blk_pl[p], dbx, last);
            end
        end
    endfunction

    function automatic int rand_plane(input int prev);
        int kind = int'($urandom_range(0, 5));
        int mask = (1 << NP) - 1;
        int res;
        case (kind)
            0:       res = prev;
            1:       res = prev ^ mask;
            2:       res = 0;
            3:       res = prev ^ (3 << $urandom_range(0, NP - 2));
            4:       res = prev ^ (1 << $urandom_range(0, NP - 1));
            default: res = int'($urandom_range(0, mask));
        endcase
        return res & mask;
    endfunction

    function automatic int plane_beat(input int pl);
        return (pl << (DATA_W - NP)) | int'($urandom_range(0, (1 << (DATA_W - NP)) - 1));
    endfunction

    // Entered and left at posedge+1; waits counts cycles with rdy_o low.
    task automatic send_beat(input int d, output int waits);
        int w = 0;
        bit ok = 1'b0;
        vld_i  = 1'b1;
        data_i = DATA_W'(d);
        while (!ok && w < 500) begin
            @(negedge clk_i);
            ok = rdy_o;
            @(posedge clk_i);
            #1;
            if (!ok) w++;
        end
        if (!ok) check_eq("accept_timeout", 0, 1);
        vld_i = 1'b0;
        waits = w;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic drive_block(input int gap_max);
        int w;
        idle(int'($urandom_range(0, gap_max)));
        send_beat(blk_base, w);
        waits_arr[0] = w;
        for (int p = 0; p <= DATA_W; p++) begin
            idle(int'($urandom_range(0, gap_max)));
            send_beat(plane_beat(blk_pl[p]), w);
            waits_arr[p + 1] = w;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            idle(1);
            t++;
        end
        check_eq("drain", exp_q.size(), 0);
        idle(2);
    endtask

    task automatic set_planes(input int first, input int rest);
        blk_pl[0] = first;
        for (int p = 1; p <= DATA_W; p++) blk_pl[p] = rest;
    endtask

    // Output-ready driver.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            rdy_i = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // Output monitor: scoreboard on handshakes and stability while stalled.
    initial begin
        bit                  stall = 1'b0;
        logic [DATA_W-1:0]   pd;
        logic [LOG_DATA_W:0] pl;
        logic                plst;
        sym_t                s;
        forever begin
            @(negedge clk_i);
            if (stall) begin
                check_eq("stall_vld",  int'(vld_o),  1);
                check_eq("stall_data", int'(data_o), int'(pd));
                check_eq("stall_len",  int'(len_o),  int'(pl));
                check_eq("stall_last", int'(last_o), int'(plst));
            end
            stall = vld_o && !rdy_i;
            pd    = data_o;
            pl    = len_o;
            plst  = last_o;
            if (vld_o && rdy_i) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_sym", int'(data_o), -1);
                end else begin
                    s = exp_q.pop_front();
                    check_eq("sym_data", int'(data_o), s.dat);
                    check_eq("sym_len",  int'(len_o),  s.len);
                    check_eq("sym_last", int'(last_o), int'(s.last));
                end
            end
        end
    end

    initial begin
        int w;
        int prev;

        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check_eq("rst_vld",  int'(vld_o),  0);
        check_eq("rst_data", int'(data_o), 0);
        check_eq("rst_len",  int'(len_o),  0);
        check_eq("rst_last", int'(last_o), 0);
        check_eq("rst_rdy",  int'(rdy_o),  1);
        @(posedge clk_i);
        #1;

        // Base then nine zero planes: run of 9.
        blk_base = 'hA5; set_planes(0, 0);
        push_lit('hA5, 8, 0); push_lit('h3C, 6, 1);
        drive_block(0); wait_drain();

        // Single one, zero plane, then a run of 7.
        blk_base = 'h00; set_planes('b0000100, 0);
        push_lit('h00, 8, 0); push_lit('h1A, 8, 0); push_lit('h08, 5, 0); push_lit('h34, 6, 1);
        drive_block(0); wait_drain();

        // Adjacent pair k=4, then run of 8.
        blk_base = 'h3C; set_planes('b0110000, 'b0110000);
        push_lit('h3C, 8, 0); push_lit('h14, 8, 0); push_lit('h38, 6, 1);
        drive_block(0); wait_drain();

        // Raw plane, then run of 8.
        blk_base = 'hFF; set_planes('b1010101, 'b1010101);
        push_lit('hFF, 8, 0); push_lit('hD5, 8, 0); push_lit('h38, 6, 1);
        drive_block(0); wait_drain();

        // Run of 1 flushed ahead of an all-ones dbx: exactly one bubble.
        blk_base = 'h81; set_planes(0, 'h7F);
        push_lit('h81, 8, 0); push_lit('h40, 2, 0); push_lit('h00, 5, 0); push_lit('h34, 6, 1);
        drive_block(0);
        check_eq("no_bubble_plane0", waits_arr[1], 0);
        check_eq("flush_bubble",     waits_arr[2], 1);
        wait_drain();

        // Downstream stall for 5 cycles with a symbol held on the output.
        rdy_force = 1'b0;
        idle(2);
        blk_base = 'h5A;
        prev = 1;
        blk_pl[0] = 1;
        for (int p = 1; p <= DATA_W; p++) begin
            blk_pl[p] = rand_plane(prev);
            prev = blk_pl[p];
        end
        model_block();
        send_beat(blk_base, w);
        vld_i  = 1'b1;
        data_i = DATA_W'(plane_beat(blk_pl[0]));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check_eq("hold_rdy_o", int'(rdy_o),  0);
            check_eq("hold_data",  int'(data_o), 'h5A);
            check_eq("hold_len",   int'(len_o),  8);
            @(posedge clk_i);
            #1;
        end
        rdy_force = 1'b1;
        for (int p = 0; p <= DATA_W; p++) send_beat(plane_beat(blk_pl[p]), w);
        wait_drain();

        // Soft clear with a run of 2 pending.
        blk_base = 'h11;
        push_sym('h11, DATA_W, 1'b0);
        plane_sym(1, 1, 1'b0);
        plane_sym(3, 2, 1'b0);
        send_beat('h11, w);
        send_beat(plane_beat(1), w);
        send_beat(plane_beat(3), w);
        send_beat(plane_beat(3), w);
        send_beat(plane_beat(3), w);
        idle(2);
        clr_i = 1'b1;
        idle(1);
        clr_i = 1'b0;
        @(negedge clk_i);
        check_eq("clr_vld", int'(vld_o), 0);
        check_eq("clr_rdy", int'(rdy_o), 1);
        @(posedge clk_i);
        #1;
        idle(4);
        check_eq("clr_no_run_sym", exp_q.size(), 0);
        blk_base = 'hC3;
        prev = 0;
        for (int p = 0; p <= DATA_W; p++) begin
            blk_pl[p] = rand_plane(prev);
            prev = blk_pl[p];
        end
        model_block();
        drive_block(0);
        wait_drain();

        // Random blocks under random backpressure and input gaps.
        rnd_rdy = 1'b1;
        for (int b = 0; b < 40; b++) begin
            blk_base = int'($urandom_range(0, (1 << DATA_W) - 1));
            prev = 0;
            for (int p = 0; p <= DATA_W; p++) begin
                blk_pl[p] = rand_plane(prev);
                prev = blk_pl[p];
            end
            model_block();
            drive_block(2);
        end
        wait_drain();
        rnd_rdy = 1'b0;
        idle(3);
        check_eq("leftover", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
